// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the PC, issues 1-cycle-latency imem requests and
// buffers returned instructions in a small show-ahead FIFO toward the IF/ID register.
module ifetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_pc4,
   output logic [31:0] out_instr,
   output logic        out_halt
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [31:0] HALT_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH     = 2'd0,
      HALT_PEND = 2'd1,
      HALTED    = 2'd2
   } state_t;

   state_t        state_reg, state_next;
   logic [31:0]   pc_reg, pc_next;
   logic          inflight_reg, inflight_next;
   logic [31:0]   inflight_pc_reg, inflight_pc_next;
   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0] count_reg;

   logic [31:0] pc_mem    [DEPTH];
   logic [31:0] instr_mem [DEPTH];
   logic        halt_mem  [DEPTH];

   logic        empty, pop, space, push, flush;
   logic [31:0] push_pc, push_instr;
   logic        push_halt;
   logic [CW:0] occupancy;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty     = (count_reg == '0);
   assign out_valid = rst & ~empty & ~redirect_valid;
   assign pop       = out_valid & out_ready;

   // Slots already committed (stored plus the response still on its way) decide if we may ask again.
   assign occupancy = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg} - {{CW{1'b0}}, pop};
   assign space     = occupancy < (CW + 1)'(DEPTH);

   assign imem_addr = pc_reg;

   always_comb begin
      state_next       = state_reg;
      pc_next          = pc_reg;
      inflight_next    = 1'b0;
      inflight_pc_next = inflight_pc_reg;
      imem_req         = 1'b0;
      flush            = 1'b0;
      push             = 1'b0;
      push_pc          = inflight_pc_reg;
      push_instr       = imem_rdata;
      push_halt        = 1'b0;

      if (redirect_valid) begin
         // Any response arriving now belongs to the wrong path and is dropped with the flush.
         flush      = 1'b1;
         pc_next    = redirect_pc;
         state_next = FETCH;
      end else begin
         if (inflight_reg) begin
            push = 1'b1;
         end
         case (state_reg)
            FETCH: begin
               if (pc_reg[1:0] != 2'b00) begin
                  state_next = HALT_PEND;
               end else if (space) begin
                  imem_req         = 1'b1;
                  pc_next          = pc_reg + 32'd4;
                  inflight_next    = 1'b1;
                  inflight_pc_next = pc_reg;
               end
            end
            HALT_PEND: begin
               if (!inflight_reg && space) begin
                  push       = 1'b1;
                  push_pc    = pc_reg;
                  push_instr = HALT_INSTR;
                  push_halt  = 1'b1;
                  state_next = HALTED;
               end
            end
            HALTED: begin
            end
            default: state_next = FETCH;
         endcase
      end

      if (!rst) begin
         imem_req = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg       <= FETCH;
         pc_reg          <= RESET_PC;
         inflight_reg    <= 1'b0;
         inflight_pc_reg <= '0;
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         count_reg       <= '0;
      end else begin
         state_reg       <= state_next;
         pc_reg          <= pc_next;
         inflight_reg    <= inflight_next;
         inflight_pc_reg <= inflight_pc_next;
         if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
         end else begin
            if (push) begin
               wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
               rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst && push && !flush) begin
         pc_mem[wr_ptr_reg]    <= push_pc;
         instr_mem[wr_ptr_reg] <= push_instr;
         halt_mem[wr_ptr_reg]  <= push_halt;
      end
   end

   // Head fields read as zero while empty so decode never sees stale entries.
   assign out_pc    = empty ? 32'd0 : pc_mem[rd_ptr_reg];
   assign out_pc4   = empty ? 32'd0 : pc_mem[rd_ptr_reg] + 32'd4;
   assign out_instr = empty ? 32'd0 : instr_mem[rd_ptr_reg];
   assign out_halt  = ~empty & halt_mem[rd_ptr_reg];

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a one-cycle instruction memory model answers each request
// with instr_of(addr); each scenario task checks the cycle-exact outputs inline.
module tb_ifetch_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc, out_pc4, out_instr;
   logic        out_halt;

   int errors = 0;
   int checks = 0;

   ifetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_pc4(out_pc4), .out_instr(out_instr), .out_halt(out_halt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst && out_valid && out_ready)
         $display("pop pc=%h pc4=%h instr=%h halt=%b", out_pc, out_pc4, out_instr, out_halt);
   end

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h5A00_0000;
   endfunction

   // Advance one clock; the memory model answers the request seen before the edge.
   task automatic next_cycle();
      logic        r;
      logic [31:0] a;
      r = imem_req;
      a = imem_addr;
      @(posedge clk);
      #1;
      imem_rdata = r ? instr_of(a) : 32'hDEAD_BEEF;
   endtask

   task automatic test_reset();
      rst = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0;
      next_cycle(); next_cycle(); #1;
      checks++;
      if ({out_valid, imem_req, out_halt} !== 3'b000) begin
         errors++; $display("FAIL reset_ctrl got=%b exp=000", {out_valid, imem_req, out_halt});
      end
      checks++;
      if ({out_pc, out_pc4, out_instr} !== 96'd0) begin
         errors++; $display("FAIL reset_data got=%h/%h/%h exp=0/0/0", out_pc, out_pc4, out_instr);
      end
   endtask

   // Cycles 0..7 after reset release: one request per cycle, head appears from cycle 2.
   task automatic test_stream();
      rst = 1'b1; #1;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) begin next_cycle(); #1; end
         checks++;
         if ({imem_req, imem_addr} !== {1'b1, 32'(4 * k)}) begin
            errors++; $display("FAIL stream_req k=%0d got=%b/%h exp=1/%h", k, imem_req, imem_addr, 4 * k);
         end
         checks++;
         if (k < 2) begin
            if (out_valid !== 1'b0) begin
               errors++; $display("FAIL stream_early_valid k=%0d got=%b exp=0", k, out_valid);
            end
         end else if ({out_valid, out_pc, out_pc4, out_instr} !==
                      {1'b1, 32'(4 * (k - 2)), 32'(4 * (k - 1)), instr_of(32'(4 * (k - 2)))}) begin
            errors++; $display("FAIL stream_head k=%0d got=%b/%h/%h/%h exp pc=%h", k, out_valid, out_pc,
                               out_pc4, out_instr, 4 * (k - 2));
         end
      end
   endtask

   // Cycles 8..12 stalled, 13..16 resumed.
   task automatic test_stall();
      for (int c = 8; c <= 12; c++) begin
         next_cycle(); out_ready = 1'b0; #1;
         checks++;
         if ({imem_req, out_valid, out_pc} !== {1'b0, 1'b1, 32'd24}) begin
            errors++; $display("FAIL stall c=%0d got req=%b valid=%b pc=%h exp req=0 valid=1 pc=18", c,
                               imem_req, out_valid, out_pc);
         end
      end
      for (int c = 13; c <= 16; c++) begin
         next_cycle(); out_ready = 1'b1; #1;
         checks++;
         if ({imem_req, imem_addr} !== {1'b1, 32'(32 + 4 * (c - 13))}) begin
            errors++; $display("FAIL resume_req c=%0d got=%b/%h exp=1/%h", c, imem_req, imem_addr,
                               32 + 4 * (c - 13));
         end
         checks++;
         if ({out_valid, out_pc, out_instr} !== {1'b1, 32'(24 + 4 * (c - 13)), instr_of(32'(24 + 4 * (c - 13)))}) begin
            errors++; $display("FAIL resume_head c=%0d got=%b/%h/%h exp pc=%h", c, out_valid, out_pc,
                               out_instr, 24 + 4 * (c - 13));
         end
      end
   endtask

   // Cycle 17: head 40, 44 in flight; redirect to 0x100 with out_ready high.
   task automatic test_redirect();
      next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
      checks++;
      if ({out_valid, imem_req} !== 2'b00) begin
         errors++; $display("FAIL redir_cycle got valid=%b req=%b exp 0 0", out_valid, imem_req);
      end
      next_cycle(); redirect_valid = 1'b0; #1;
      checks++;
      if ({out_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100}) begin
         errors++; $display("FAIL redir_first_req got=%b/%b/%h exp=0/1/100", out_valid, imem_req, imem_addr);
      end
      next_cycle(); #1;
      checks++;
      if ({out_valid, imem_addr} !== {1'b0, 32'h104}) begin
         errors++; $display("FAIL redir_gap got=%b/%h exp=0/104", out_valid, imem_addr);
      end
      next_cycle(); #1;
      checks++;
      if ({out_valid, out_pc, out_pc4, out_instr} !== {1'b1, 32'h100, 32'h104, instr_of(32'h100)}) begin
         errors++; $display("FAIL redir_head got=%b/%h/%h/%h exp=1/100/104", out_valid, out_pc, out_pc4, out_instr);
      end
      next_cycle(); #1;
      checks++;
      if ({out_valid, out_pc, imem_addr} !== {1'b1, 32'h104, 32'h10C}) begin
         errors++; $display("FAIL redir_next got=%b/%h/%h exp=1/104/10c", out_valid, out_pc, imem_addr);
      end
   endtask

   task automatic test_misaligned();
      next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h102; #1;
      next_cycle(); redirect_valid = 1'b0; #1;
      for (int c = 0; c < 2; c++) begin
         checks++;
         if ({imem_req, out_valid} !== 2'b00) begin
            errors++; $display("FAIL misalign_idle c=%0d got req=%b valid=%b exp 0 0", c, imem_req, out_valid);
         end
         next_cycle(); #1;
      end
      checks++;
      if ({out_valid, out_pc, out_pc4, out_instr, out_halt, imem_req} !==
          {1'b1, 32'h102, 32'h106, 32'h13, 1'b1, 1'b0}) begin
         errors++; $display("FAIL halt_entry got=%b/%h/%h/%h halt=%b req=%b exp=1/102/106/13 halt=1 req=0",
                            out_valid, out_pc, out_pc4, out_instr, out_halt, imem_req);
      end
      for (int c = 0; c < 2; c++) begin
         next_cycle(); #1;
         checks++;
         if ({imem_req, out_valid} !== 2'b00) begin
            errors++; $display("FAIL halted_idle c=%0d got req=%b valid=%b exp 0 0", c, imem_req, out_valid);
         end
      end
   endtask

   task automatic test_halted_redirect();
      next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
      next_cycle(); redirect_valid = 1'b0; #1;
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h200}) begin
         errors++; $display("FAIL unhalt_req got=%b/%h exp=1/200", imem_req, imem_addr);
      end
      next_cycle(); #1;
      next_cycle(); #1;
      checks++;
      if ({out_valid, out_pc, out_halt, out_instr} !== {1'b1, 32'h200, 1'b0, instr_of(32'h200)}) begin
         errors++; $display("FAIL unhalt_head got=%b/%h halt=%b instr=%h exp=1/200 halt=0", out_valid, out_pc,
                            out_halt, out_instr);
      end
   endtask

   task automatic test_reset_full();
      next_cycle(); out_ready = 1'b0; #1;
      next_cycle(); #1;
      checks++;
      if ({imem_req, out_valid, out_pc} !== {1'b0, 1'b1, 32'h204}) begin
         errors++; $display("FAIL full_hold got req=%b valid=%b pc=%h exp 0 1 204", imem_req, out_valid, out_pc);
      end
      rst = 1'b0;
      next_cycle(); out_ready = 1'b1; #1;
      checks++;
      if ({out_valid, imem_req} !== 2'b00) begin
         errors++; $display("FAIL midreset got valid=%b req=%b exp 0 0", out_valid, imem_req);
      end
      rst = 1'b1; #1;
      checks++;
      if ({imem_req, imem_addr, out_valid} !== {1'b1, 32'h0, 1'b0}) begin
         errors++; $display("FAIL restart_req got=%b/%h valid=%b exp=1/0 valid=0", imem_req, imem_addr, out_valid);
      end
      next_cycle(); #1;
      next_cycle(); #1;
      checks++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h0, instr_of(32'h0)}) begin
         errors++; $display("FAIL restart_head got=%b/%h/%h exp=1/0", out_valid, out_pc, out_instr);
      end
   endtask

   task automatic test_wrap();
      next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
      next_cycle(); redirect_valid = 1'b0; #1;
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
         errors++; $display("FAIL wrap_req0 got=%b/%h exp=1/fffffffc", imem_req, imem_addr);
      end
      next_cycle(); #1;
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
         errors++; $display("FAIL wrap_req1 got=%b/%h exp=1/0", imem_req, imem_addr);
      end
      next_cycle(); #1;
      checks++;
      if ({out_valid, out_pc, out_pc4} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
         errors++; $display("FAIL wrap_head got=%b/%h/%h exp=1/fffffffc/0", out_valid, out_pc, out_pc4);
      end
      next_cycle(); #1;
      checks++;
      if ({out_valid, out_pc, out_pc4} !== {1'b1, 32'h0, 32'h4}) begin
         errors++; $display("FAIL wrap_next got=%b/%h/%h exp=1/0/4", out_valid, out_pc, out_pc4);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_misaligned();
      test_halted_redirect();
      test_reset_full();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
